// File: rtl/led_ctrl.sv
// led_ctrl: multi-channel LED pattern controller (off / on / blink / burst).
// A shared prescaler produces the pattern tick. Each channel keeps its own
// config and counters, and o_led is registered from the current channel state.
//
// Burst FSM (one per channel)
//   state    | meaning
//   st_pulse | LED lit; r_sub counts the pulse width
//   st_gap   | LED dark; r_sub counts the gap width, and the end of a gap bumps r_pcnt
//   st_rest  | all pulses for this period are sent; LED dark until the period wraps

module led_ctrl #(
    parameter int p_local_clk_freq = 74_250_000,
    parameter int p_tick_hz        = 1000,
    parameter int p_channels       = 4,
    parameter bit p_active_low     = 1'b0
) (
    input  logic                  i_local_clk,
    input  logic                  i_rst,
    input  logic                  i_cfg_wr,
    input  logic [3:0]            i_cfg_ch,
    input  logic [1:0]            i_cfg_mode,
    input  logic [15:0]           i_cfg_period,
    input  logic [15:0]           i_cfg_on,
    input  logic [3:0]            i_cfg_pulses,
    output logic                  o_tick,
    output logic [p_channels-1:0] o_led
);

    localparam int c_div   = p_local_clk_freq / p_tick_hz;
    localparam int c_div_w = $clog2(c_div);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);

    localparam logic [15:0] c_rst_period = 16'(p_tick_hz);
    localparam logic [15:0] c_rst_on     = 16'(p_tick_hz / 2);

    localparam logic [1:0] c_mode_off   = 2'd0;
    localparam logic [1:0] c_mode_on    = 2'd1;
    localparam logic [1:0] c_mode_blink = 2'd2;
    localparam logic [1:0] c_mode_burst = 2'd3;

    typedef enum logic [1:0] {
        st_pulse = 2'd0,
        st_gap   = 2'd1,
        st_rest  = 2'd2
    } burst_state_t;

    logic [c_div_w-1:0] r_div;
    logic               r_tick;

    logic [1:0]   r_mode   [p_channels];
    logic [15:0]  r_period [p_channels];
    logic [15:0]  r_on     [p_channels];
    logic [3:0]   r_pulses [p_channels];
    logic [15:0]  r_ms     [p_channels];
    logic [15:0]  r_sub    [p_channels];
    logic [3:0]   r_pcnt   [p_channels];
    burst_state_t r_state  [p_channels];

    logic [p_channels-1:0] w_led;
    logic [p_channels-1:0] w_run;

    assign o_tick = r_tick;

    // Prescaler: free-running 0..DIV-1 counter with a registered one-cycle tick.
    always_ff @(posedge i_local_clk) begin
        if (i_rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_div == c_div_last);
            r_div  <= (r_div == c_div_last) ? '0 : r_div + 1'b1;
        end
    end

    // Per-channel run enable and LED level decoded from mode and counters.
    always_comb begin
        w_run = '0;
        w_led = '0;
        for (int c = 0; c < p_channels; c++) begin
            case (r_mode[c])
                c_mode_on: w_led[c] = 1'b1;
                c_mode_blink: begin
                    w_run[c] = (r_period[c] != 16'd0);
                    w_led[c] = w_run[c] && (r_ms[c] < r_on[c]);
                end
                c_mode_burst: begin
                    w_run[c] = (r_period[c] != 16'd0) && (r_on[c] != 16'd0) &&
                               (r_pulses[c] != 4'd0);
                    w_led[c] = w_run[c] && (r_state[c] == st_pulse);
                end
                default: ;
            endcase
        end
    end

    // Channel config and counters; a write beats a coincident tick, and the wrap beats a sub-phase step.
    always_ff @(posedge i_local_clk) begin
        for (int c = 0; c < p_channels; c++) begin
            if (i_rst) begin
                r_mode[c]   <= (c == 0) ? c_mode_blink : c_mode_off;
                r_period[c] <= (c == 0) ? c_rst_period : 16'd0;
                r_on[c]     <= (c == 0) ? c_rst_on : 16'd0;
                r_pulses[c] <= 4'd0;
                r_ms[c]     <= 16'd0;
                r_sub[c]    <= 16'd0;
                r_pcnt[c]   <= 4'd0;
                r_state[c]  <= st_pulse;
            end else if (i_cfg_wr && (int'(i_cfg_ch) == c)) begin
                r_mode[c]   <= i_cfg_mode;
                r_period[c] <= i_cfg_period;
                r_on[c]     <= i_cfg_on;
                r_pulses[c] <= i_cfg_pulses;
                r_ms[c]     <= 16'd0;
                r_sub[c]    <= 16'd0;
                r_pcnt[c]   <= 4'd0;
                r_state[c]  <= st_pulse;
            end else if (r_tick && w_run[c]) begin
                if (r_ms[c] == r_period[c] - 16'd1) begin
                    r_ms[c]    <= 16'd0;
                    r_sub[c]   <= 16'd0;
                    r_pcnt[c]  <= 4'd0;
                    r_state[c] <= st_pulse;
                end else begin
                    r_ms[c] <= r_ms[c] + 16'd1;
                    if (r_mode[c] == c_mode_burst) begin
                        case (r_state[c])
                            st_pulse: begin
                                if (r_sub[c] == r_on[c] - 16'd1) begin
                                    r_sub[c]   <= 16'd0;
                                    r_state[c] <= st_gap;
                                end else begin
                                    r_sub[c] <= r_sub[c] + 16'd1;
                                end
                            end
                            st_gap: begin
                                if (r_sub[c] == r_on[c] - 16'd1) begin
                                    r_sub[c]   <= 16'd0;
                                    r_pcnt[c]  <= r_pcnt[c] + 4'd1;
                                    r_state[c] <= (r_pcnt[c] + 4'd1 == r_pulses[c]) ?
                                                  st_rest : st_pulse;
                                end else begin
                                    r_sub[c] <= r_sub[c] + 16'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    // Output register with optional inversion for active-low LEDs.
    always_ff @(posedge i_local_clk) begin
        if (i_rst) begin
            o_led <= {p_channels{p_active_low}};
        end else begin
            o_led <= w_led ^ {p_channels{p_active_low}};
        end
    end

endmodule
